hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use, branch-compare and mult/div
// interlocks, a small mult/div sequencer and a saturating stall counter.

module hazard_src_match (
    input  logic [4:0] src_addr,
    input  logic       src_use,
    input  logic [4:0] e_rd,
    input  logic [4:0] m_rd,
    output logic       e_hit,
    output logic       m_hit
);
    // r0 is hard-wired zero, so it never creates a dependency
    assign e_hit = src_use && (e_rd != 5'd0) && (e_rd == src_addr);
    assign m_hit = src_use && (m_rd != 5'd0) && (m_rd == src_addr);
endmodule

module hazard_stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       D_RsAddr,
    input  logic [4:0]       D_RtAddr,
    input  logic             D_UseRs,
    input  logic             D_UseRt,
    input  logic             D_Branch,
    input  logic             D_UsesMD,
    input  logic             E_WriteReg,
    input  logic             E_MemRead,
    input  logic [4:0]       E_RD,
    input  logic             M_MemRead,
    input  logic [4:0]       M_RD,
    input  logic             E_MDStart,
    input  logic             E_MDIsDiv,
    input  logic             StallClr,
    output logic             PC_En,
    output logic             D_En,
    output logic             E_Flush,
    output logic             MD_Busy,
    output logic             MD_Done,
    output logic [CNT_W-1:0] StallCnt
);
    localparam int NUM_SRC = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [7:0] MULT_LD = 8'(MULT_CYC - 1);
    localparam logic [7:0] DIV_LD  = 8'(DIV_CYC - 1);

    typedef struct packed {
        logic [4:0] addr;
        logic       use_src;
    } src_req_t;

    src_req_t [NUM_SRC-1:0] src_req;
    logic     [NUM_SRC-1:0] e_hit;
    logic     [NUM_SRC-1:0] m_hit;

    logic [1:0]       md_state, md_state_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic             ld_stall, br_stall, md_stall, stall;

    assign src_req[0] = '{addr: D_RsAddr, use_src: D_UseRs};
    assign src_req[1] = '{addr: D_RtAddr, use_src: D_UseRt};

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            hazard_src_match u_match (
                .src_addr (src_req[g].addr),
                .src_use  (src_req[g].use_src),
                .e_rd     (E_RD),
                .m_rd     (M_RD),
                .e_hit    (e_hit[g]),
                .m_hit    (m_hit[g])
            );
        end
    endgenerate

    assign ld_stall = E_MemRead && (|e_hit);
    assign br_stall = D_Branch && ((E_WriteReg && (|e_hit)) || (M_MemRead && (|m_hit)));
    assign md_stall = D_UsesMD && ((md_state == BUSY) || E_MDStart);
    assign stall    = ld_stall || br_stall || md_stall;

    // Hold the front end frozen with a bubble in E for as long as reset is low
    assign PC_En   = rst && !stall;
    assign D_En    = rst && !stall;
    assign E_Flush = !rst || stall;

    assign MD_Busy  = (md_state == BUSY);
    assign MD_Done  = (md_state == DONE);
    assign StallCnt = stall_cnt;

    always_comb begin
        md_state_nxt = md_state;
        cnt_nxt      = cnt;
        case (md_state)
            IDLE, DONE: begin
                if (E_MDStart) begin
                    md_state_nxt = BUSY;
                    cnt_nxt      = E_MDIsDiv ? DIV_LD : MULT_LD;
                end else begin
                    md_state_nxt = IDLE;
                end
            end
            BUSY: begin
                // a second start while running is dropped, not queued
                if (cnt != 8'd0) cnt_nxt = cnt - 8'd1;
                else             md_state_nxt = DONE;
            end
            default: md_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_state <= IDLE;
            cnt      <= 8'd0;
        end else begin
            md_state <= md_state_nxt;
            cnt      <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  stall_cnt <= '0;
        else if (StallClr)         stall_cnt <= '0;
        else if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed + random bench for hazard_stall_ctrl against a cycle-level model.

module tb_hazard_stall_ctrl;
    localparam int MULT = 5;
    localparam int DIV  = 10;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] D_RsAddr, D_RtAddr, E_RD, M_RD;
    logic D_UseRs, D_UseRt, D_Branch, D_UsesMD, E_WriteReg, E_MemRead;
    logic M_MemRead, E_MDStart, E_MDIsDiv, StallClr;
    logic PC_En, D_En, E_Flush, MD_Busy, MD_Done;
    logic [CW-1:0] StallCnt;

    int total = 0;
    int bad   = 0;

    // model: remaining busy cycles, done flag, stall count
    int m_left = 0;
    bit m_done = 0;
    int m_sc   = 0;
    int busy_seen, done_seen;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MULT_CYC(MULT), .DIV_CYC(DIV), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .D_RsAddr(D_RsAddr), .D_RtAddr(D_RtAddr),
        .D_UseRs(D_UseRs), .D_UseRt(D_UseRt),
        .D_Branch(D_Branch), .D_UsesMD(D_UsesMD),
        .E_WriteReg(E_WriteReg), .E_MemRead(E_MemRead), .E_RD(E_RD),
        .M_MemRead(M_MemRead), .M_RD(M_RD),
        .E_MDStart(E_MDStart), .E_MDIsDiv(E_MDIsDiv), .StallClr(StallClr),
        .PC_En(PC_En), .D_En(D_En), .E_Flush(E_Flush),
        .MD_Busy(MD_Busy), .MD_Done(MD_Done), .StallCnt(StallCnt)
    );

    function automatic bit hits(input logic [4:0] x);
        return (x != 0) && ((D_UseRs && x == D_RsAddr) || (D_UseRt && x == D_RtAddr));
    endfunction

    function automatic bit m_stall();
        return (E_MemRead && hits(E_RD))
            || (D_Branch && ((E_WriteReg && hits(E_RD)) || (M_MemRead && hits(M_RD))))
            || (D_UsesMD && (m_left > 0 || E_MDStart));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_done = 0; m_sc = 0;
    endtask

    task automatic idle_inputs();
        D_RsAddr = 0; D_RtAddr = 0; E_RD = 0; M_RD = 0;
        D_UseRs = 0; D_UseRt = 0; D_Branch = 0; D_UsesMD = 0;
        E_WriteReg = 0; E_MemRead = 0; M_MemRead = 0;
        E_MDStart = 0; E_MDIsDiv = 0; StallClr = 0;
    endtask

    // check outputs mid-low-phase, advance model across the rising edge
    task automatic tick();
        bit s;
        int n_left, n_sc;
        bit n_done;
        #1;
        s = rst && m_stall();
        chk("pc_en",   32'(PC_En),   32'(rst && !s));
        chk("d_en",    32'(D_En),    32'(rst && !s));
        chk("e_flush", 32'(E_Flush), 32'(!rst || s));
        chk("md_busy", 32'(MD_Busy), 32'(m_left > 0));
        chk("md_done", 32'(MD_Done), 32'(m_done));
        chk("stallcnt", 32'(StallCnt), 32'(m_sc));
        busy_seen += int'(MD_Busy);
        done_seen += int'(MD_Done);
        n_left = m_left; n_done = m_done; n_sc = m_sc;
        if (rst) begin
            if (m_left > 0) begin
                n_left = m_left - 1;
                n_done = (n_left == 0);
            end else if (E_MDStart) begin
                n_left = E_MDIsDiv ? DIV : MULT;
                n_done = 0;
            end else begin
                n_done = 0;
            end
            if (StallClr)                 n_sc = 0;
            else if (s && m_sc < CMAX)    n_sc = m_sc + 1;
        end
        @(posedge clk);
        m_left = n_left; m_done = n_done; m_sc = n_sc;
        @(negedge clk);
    endtask

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd8;
            2: return 5'd9;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        idle_inputs();
        rst = 0;
        model_reset();
        busy_seen = 0; done_seen = 0;
        #1;
        chk("rst_pc_en", 32'(PC_En), 0);
        chk("rst_flush", 32'(E_Flush), 1);
        tick(); tick();
        rst = 1;
        tick();

        // load-use
        E_MemRead = 1; E_RD = 8; D_RsAddr = 8; D_UseRs = 1;
        tick();
        chk("lu_cnt", 32'(StallCnt), 1);
        E_MemRead = 0;
        tick();
        E_MemRead = 1; E_RD = 0; D_RsAddr = 0;
        tick();
        chk("lu_r0_cnt", 32'(StallCnt), 1);
        idle_inputs();

        // branch compare against M load, E writer, E non-writer
        D_Branch = 1; D_RtAddr = 9; D_UseRt = 1; M_MemRead = 1; M_RD = 9;
        tick();
        M_MemRead = 0; E_WriteReg = 1; E_RD = 9;
        tick();
        E_WriteReg = 0;
        tick();
        chk("br_cnt", 32'(StallCnt), 3);
        idle_inputs();
        StallClr = 1; tick(); StallClr = 0;

        // multiply followed by mflo held in D
        busy_seen = 0; done_seen = 0;
        E_MDStart = 1; E_MDIsDiv = 0; D_UsesMD = 1;
        tick();
        E_MDStart = 0;
        for (int i = 0; i < 7; i++) tick();
        D_UsesMD = 0;
        chk("mul_busy_cycles", 32'(busy_seen), MULT);
        chk("mul_done_cycles", 32'(done_seen), 1);
        chk("mul_stallcnt", 32'(StallCnt), 6);
        StallClr = 1; tick(); StallClr = 0;

        // divide, ignored start in BUSY, mult accepted in the DONE cycle
        E_MDStart = 1; E_MDIsDiv = 1;
        tick();
        E_MDStart = 0;
        tick(); tick(); tick();
        E_MDStart = 1; E_MDIsDiv = 0;
        tick();
        E_MDStart = 0;
        for (int i = 0; i < 20 && !MD_Done; i++) tick();
        chk("div_done_reached", 32'(MD_Done), 1);
        busy_seen = 0;
        E_MDStart = 1; E_MDIsDiv = 0;
        tick();
        E_MDStart = 0;
        for (int i = 0; i < 7; i++) tick();
        chk("b2b_busy_cycles", 32'(busy_seen), MULT);

        // reset at the third busy cycle
        E_MDStart = 1; E_MDIsDiv = 0;
        tick();
        E_MDStart = 0;
        tick(); tick();
        chk("pre_rst_busy", 32'(MD_Busy), 1);
        rst = 0; model_reset();
        done_seen = 0;
        #1;
        chk("rst_busy_drop", 32'(MD_Busy), 0);
        chk("rst_pc_en_mid", 32'(PC_En), 0);
        tick(); tick();
        rst = 1;
        for (int i = 0; i < 6; i++) tick();
        chk("rst_no_done", 32'(done_seen), 0);

        // saturation then clear with stall still active
        E_MemRead = 1; E_RD = 8; D_RsAddr = 8; D_UseRs = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt", 32'(StallCnt), CMAX);
        StallClr = 1;
        tick();
        chk("clr_cnt", 32'(StallCnt), 0);
        idle_inputs();
        tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            D_RsAddr   = pick_addr();
            D_RtAddr   = pick_addr();
            E_RD       = pick_addr();
            M_RD       = pick_addr();
            D_UseRs    = 1'($urandom_range(0, 1));
            D_UseRt    = 1'($urandom_range(0, 1));
            D_Branch   = ($urandom_range(0, 3) == 0);
            D_UsesMD   = ($urandom_range(0, 3) == 0);
            E_WriteReg = 1'($urandom_range(0, 1));
            E_MemRead  = ($urandom_range(0, 3) == 0);
            M_MemRead  = ($urandom_range(0, 3) == 0);
            E_MDStart  = ($urandom_range(0, 7) == 0);
            E_MDIsDiv  = 1'($urandom_range(0, 1));
            StallClr   = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
